// File: rtl/mcu_pkg.sv
// ---------------------------------------------------------------------------
// mcu_pkg : shared state, mode and LFSR constants for playback control (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

package mcu_pkg;

  typedef enum logic [1:0] {
    PAUSED  = 2'd0,
    PLAYING = 2'd1,
    CHANGE  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_STOP    = 2'd0;
  localparam logic [1:0] MODE_SEQ     = 2'd1;
  localparam logic [1:0] MODE_LOOP    = 2'd2;
  localparam logic [1:0] MODE_SHUFFLE = 2'd3;

  // Feedback taps 8,6,5,4 (bits 7,5,4,3) give a maximal-length sequence.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

`default_nettype wire

// File: rtl/mcu_seq_if.sv
// ---------------------------------------------------------------------------
// mcu_seq_if : front-panel events in, player control out (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

interface mcu_seq_if #(
  parameter int SONG_W = 2
);
  logic              play_button;
  logic              next_button;
  logic              prev_button;
  logic              song_done;
  logic [1:0]        mode;
  logic              play;
  logic              reset_player;
  logic [SONG_W-1:0] song;

  modport master (
    output play_button, next_button, prev_button, song_done, mode,
    input  play, reset_player, song
  );

  modport slave (
    input  play_button, next_button, prev_button, song_done, mode,
    output play, reset_player, song
  );
endinterface

`default_nettype wire

// File: rtl/mcu_seq_lfsr8.sv
// ---------------------------------------------------------------------------
// lfsr8 : free-running 8-bit Fibonacci LFSR, reloads SEED on reset (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module lfsr8
  import mcu_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  wire logic       clk,
  input  wire logic       reset,
  output logic      [7:0] value
);

  logic [7:0] r_value;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_value <= SEED;
    end else begin
      r_value <= {r_value[6:0], ^(r_value & LFSR_TAPS)};
    end
  end

  assign value = r_value;

endmodule

`default_nettype wire

// File: rtl/mcu_seq.sv
// ---------------------------------------------------------------------------
// mcu_seq : play/pause/next/prev controller with end-of-song modes (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module mcu_seq
  import mcu_pkg::*;
#(
  parameter int         NUM_SONGS = 4,
  parameter int         SONG_W    = 2,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  wire logic clk,
  input  wire logic reset,
  mcu_seq_if.slave  bus
);

  localparam logic [SONG_W:0] c_num  = (SONG_W+1)'(NUM_SONGS);
  localparam logic [SONG_W:0] c_last = c_num - (SONG_W+1)'(1);
  localparam logic [SONG_W:0] c_one  = (SONG_W+1)'(1);
  localparam logic [7:0]      c_mask8 = 8'((1 << SONG_W) - 1);
  localparam logic [7:0]      c_num8  = 8'(NUM_SONGS);

  state_t            r_state, w_state_nxt;
  logic [SONG_W-1:0] r_song, w_song_nxt;
  logic              r_resume, w_resume_nxt;
  logic              r_play;
  logic              r_reset_player;
  logic [7:0]        w_lfsr;

  logic [SONG_W:0]   w_song_ext;
  logic [SONG_W-1:0] w_song_inc;
  logic [SONG_W-1:0] w_song_dec;
  logic [SONG_W-1:0] w_shuf_raw;
  logic [SONG_W-1:0] w_shuf;

  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .value (w_lfsr)
  );

  // Index arithmetic is one bit wider so wraps never depend on overflow.
  assign w_song_ext = {1'b0, r_song};
  assign w_song_inc = (w_song_ext == c_last) ? '0 : SONG_W'(w_song_ext + c_one);
  assign w_song_dec = (r_song == '0) ? SONG_W'(c_last) : r_song - SONG_W'(1);
  assign w_shuf_raw = SONG_W'((w_lfsr & c_mask8) % c_num8);
  assign w_shuf     = (w_shuf_raw == r_song) ? w_song_inc : w_shuf_raw;

  always_comb begin
    w_state_nxt  = r_state;
    w_song_nxt   = r_song;
    w_resume_nxt = r_resume;
    case (r_state)
      PAUSED: begin
        if (bus.next_button) begin
          w_song_nxt   = w_song_inc;
          w_resume_nxt = 1'b0;
          w_state_nxt  = CHANGE;
        end else if (bus.prev_button) begin
          w_song_nxt   = w_song_dec;
          w_resume_nxt = 1'b0;
          w_state_nxt  = CHANGE;
        end else if (bus.play_button) begin
          w_state_nxt  = PLAYING;
        end
      end
      PLAYING: begin
        if (bus.song_done) begin
          w_state_nxt = CHANGE;
          case (bus.mode)
            MODE_STOP: begin
              w_resume_nxt = 1'b0;
            end
            MODE_SEQ: begin
              w_song_nxt   = w_song_inc;
              w_resume_nxt = (w_song_ext != c_last);
            end
            MODE_LOOP: begin
              w_song_nxt   = w_song_inc;
              w_resume_nxt = 1'b1;
            end
            default: begin
              w_song_nxt   = w_shuf;
              w_resume_nxt = 1'b1;
            end
          endcase
        end else if (bus.next_button) begin
          w_song_nxt   = w_song_inc;
          w_resume_nxt = 1'b1;
          w_state_nxt  = CHANGE;
        end else if (bus.prev_button) begin
          w_song_nxt   = w_song_dec;
          w_resume_nxt = 1'b1;
          w_state_nxt  = CHANGE;
        end else if (bus.play_button) begin
          w_state_nxt  = PAUSED;
        end
      end
      CHANGE: begin
        w_state_nxt = r_resume ? PLAYING : PAUSED;
      end
      default: begin
        w_state_nxt = PAUSED;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= PAUSED;
      r_song         <= '0;
      r_resume       <= 1'b0;
      r_play         <= 1'b0;
      r_reset_player <= 1'b1;
    end else begin
      r_state        <= w_state_nxt;
      r_song         <= w_song_nxt;
      r_resume       <= w_resume_nxt;
      r_play         <= (w_state_nxt == PLAYING);
      r_reset_player <= (w_state_nxt == CHANGE);
    end
  end

  assign bus.play         = r_play;
  assign bus.reset_player = r_reset_player;
  assign bus.song         = r_song;

endmodule

`default_nettype wire

// File: tb/tb_mcu_seq.sv
// ---------------------------------------------------------------------------
// tb_mcu_seq : scoreboard bench for 4-song and 3-song controllers (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mcu_seq;

  typedef struct {
    bit         playing;
    bit         in_change;
    bit         resume;
    int         song;
    logic [7:0] lfsr;
  } model_t;

  typedef struct {
    bit play;
    bit rp;
    int song;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       pb, nb, vb, sd;
  logic [1:0] md;
  bit         started = 1'b0;
  int         checks = 0;
  int         errors = 0;

  model_t m4, m3;
  exp_t   q4[$];
  exp_t   q3[$];

  always #5 clk = ~clk;

  mcu_seq_if #(.SONG_W(2)) bus4 ();
  mcu_seq_if #(.SONG_W(2)) bus3 ();

  assign bus4.play_button = pb;
  assign bus4.next_button = nb;
  assign bus4.prev_button = vb;
  assign bus4.song_done   = sd;
  assign bus4.mode        = md;
  assign bus3.play_button = pb;
  assign bus3.next_button = nb;
  assign bus3.prev_button = vb;
  assign bus3.song_done   = sd;
  assign bus3.mode        = md;

  mcu_seq #(.NUM_SONGS(4), .SONG_W(2), .LFSR_SEED(8'hA5)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave)
  );

  mcu_seq #(.NUM_SONGS(3), .SONG_W(2), .LFSR_SEED(8'hA5)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3.slave)
  );

  function automatic logic [7:0] lfsr_next(logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic model_t model_reset();
    model_t r;
    r.playing = 0; r.in_change = 0; r.resume = 0; r.song = 0; r.lfsr = 8'hA5;
    return r;
  endfunction

  function automatic model_t step(model_t m, int n, bit p, bit nx, bit pv, bit d, int mode);
    model_t     r = m;
    logic [7:0] cur = m.lfsr;
    int         c;
    r.lfsr = lfsr_next(m.lfsr);
    if (m.in_change) begin
      r.in_change = 0;
      r.playing   = m.resume;
    end else if (m.playing && d) begin
      r.in_change = 1;
      r.playing   = 0;
      case (mode)
        0: r.resume = 0;
        1: begin
          r.resume = (m.song != n - 1);
          r.song   = (m.song == n - 1) ? 0 : m.song + 1;
        end
        2: begin
          r.resume = 1;
          r.song   = (m.song + 1) % n;
        end
        default: begin
          c = int'(cur[1:0]) % n;
          if (c == m.song) c = (m.song + 1) % n;
          r.song   = c;
          r.resume = 1;
        end
      endcase
    end else if (nx || pv) begin
      r.song      = nx ? (m.song + 1) % n : (m.song + n - 1) % n;
      r.resume    = m.playing;
      r.in_change = 1;
      r.playing   = 0;
    end else if (p) begin
      r.playing = !m.playing;
    end
    return r;
  endfunction

  function automatic exp_t expect_of(model_t m);
    exp_t e;
    e.play = m.playing && !m.in_change;
    e.rp   = m.in_change;
    e.song = m.song;
    return e;
  endfunction

  // Async reset supersedes any response still pending from the last edge.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_t e;
      m4 = model_reset();
      m3 = model_reset();
      e.play = 0; e.rp = 1; e.song = 0;
      q4.delete(); q3.delete();
      q4.push_back(e);
      q3.push_back(e);
    end else begin
      m4 = step(m4, 4, pb, nb, vb, sd, int'(md));
      m3 = step(m3, 3, pb, nb, vb, sd, int'(md));
      q4.push_back(expect_of(m4));
      q3.push_back(expect_of(m3));
    end
  end

  task automatic compare(string nm, exp_t e, logic p, logic rp, logic [1:0] s);
    checks++;
    if (p !== e.play || rp !== e.rp || s !== 2'(e.song)) begin
      errors++;
      $display("FAIL %s @%0t: play/reset_player/song got %b/%b/%0d want %0d/%0d/%0d",
               nm, $time, p, rp, s, e.play, e.rp, e.song);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      exp_t e;
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL n4_queue @%0t: got empty want one expected entry", $time);
      end else begin
        e = q4.pop_front();
        compare("n4", e, bus4.play, bus4.reset_player, bus4.song);
      end
      if (q3.size() == 0) begin
        checks++; errors++;
        $display("FAIL n3_queue @%0t: got empty want one expected entry", $time);
      end else begin
        e = q3.pop_front();
        compare("n3", e, bus3.play, bus3.reset_player, bus3.song);
      end
    end
  end

  task automatic drive(bit p, bit n, bit v, bit d, logic [1:0] m, bit r = 1'b1);
    @(posedge clk);
    #2;
    pb = p; nb = n; vb = v; sd = d; md = m; reset = r;
  endtask

  task automatic idle(int cycles, logic [1:0] m);
    repeat (cycles) drive(0, 0, 0, 0, m);
  endtask

  initial begin
    reset = 1'b0;
    pb = 0; nb = 0; vb = 0; sd = 0; md = 2'd0;
    @(posedge clk);
    started = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    idle(2, 2'd0);

    // Play toggling, then walk to the last song and exercise wraps.
    drive(1, 0, 0, 0, 2'd1); idle(1, 2'd1);
    drive(1, 0, 0, 0, 2'd1); idle(1, 2'd1);
    drive(1, 0, 0, 0, 2'd1); idle(1, 2'd1);
    repeat (3) begin drive(0, 1, 0, 0, 2'd1); idle(1, 2'd1); end
    drive(0, 1, 0, 0, 2'd1); idle(1, 2'd1);
    drive(0, 0, 1, 0, 2'd1); idle(1, 2'd1);
    drive(0, 0, 1, 0, 2'd1); idle(2, 2'd1);

    // End-of-song modes.
    drive(0, 0, 0, 1, 2'd1); idle(2, 2'd1);
    drive(1, 0, 0, 0, 2'd2); idle(1, 2'd2);
    drive(0, 0, 0, 1, 2'd2); idle(2, 2'd2);
    drive(0, 0, 0, 1, 2'd0); idle(2, 2'd0);
    drive(0, 0, 0, 1, 2'd0); idle(1, 2'd0);

    // Coincident events, and events arriving during CHANGE.
    drive(1, 0, 0, 0, 2'd2); idle(1, 2'd2);
    drive(1, 1, 0, 1, 2'd2);
    drive(0, 1, 1, 1, 2'd2); idle(2, 2'd2);

    // Shuffle run.
    repeat (50) begin
      drive(0, 0, 0, 1, 2'd3);
      drive(0, 0, 0, 0, 2'd3);
    end

    // Reset asserted while in CHANGE.
    drive(0, 1, 0, 0, 2'd2);
    drive(0, 0, 0, 0, 2'd2, 1'b0);
    drive(0, 0, 0, 0, 2'd2, 1'b1);
    idle(2, 2'd2);

    repeat (3000) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
            2'($urandom_range(0, 3)), $urandom_range(0, 199) != 0);
    end
    drive(0, 0, 0, 0, 2'd0, 1'b1);
    idle(3, 2'd0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mcu_seq.md
Name: mcu_seq

Overview:
Parametrised playback control unit for the music player. It generalises the fixed 4-song play/next controller to NUM_SONGS songs and adds a prev button, four end-of-song play modes (including LFSR shuffle) and a one-cycle song-change handshake that pulses reset_player. It sits between the debounced/one-pulsed front-panel buttons and the song_reader/note_player chain, driving play, reset_player and the song index.

Parameters:
NUM_SONGS, 4, number of songs; legal range 2..2**SONG_W.
SONG_W, 2, width of song index.
LFSR_SEED, 8'hA5, reset value of the 8-bit shuffle LFSR; must be nonzero.

Ports:
clk  input  1  system clock, all state on rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
play_button  input  1  one-cycle pulse; toggles play/pause.
next_button  input  1  one-cycle pulse; advance to next song.
prev_button  input  1  one-cycle pulse; go to previous song.
song_done  input  1  one-cycle pulse from song_reader at end of current song.
mode  input  2  end-of-song mode: 0 STOP, 1 SEQ, 2 LOOP, 3 SHUFFLE.
play  output  1  1 = player running.
reset_player  output  1  1 = rewind song_reader/note_player to start of song.
song  output  SONG_W  current song index, 0..NUM_SONGS-1.

Behaviour:
- Reset asserted (reset=0, async): state=PAUSED, song=0, play=0, reset_player=1, lfsr=LFSR_SEED, resume=0. After release first edge leaves reset_player=0.
- All outputs registered; decoded from state. PAUSED: play=0, reset_player=0. PLAYING: play=1, reset_player=0. CHANGE: play=0, reset_player=1.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4, shifts every cycle outside reset; never reaches 0.
- Events sampled on rising edge; response visible one cycle later. Priority when coincident: song_done > next > prev > play. Only one event acted on per cycle; others dropped.
- PAUSED: play_button -> PLAYING. next -> song=song+1 (wrap NUM_SONGS-1->0), resume=0, CHANGE. prev -> song=song-1 (wrap 0->NUM_SONGS-1), resume=0, CHANGE. song_done ignored.
- PLAYING: play_button -> PAUSED (song unchanged, no rewind). next/prev as above but resume=1. song_done, by mode sampled that cycle:
  STOP: song unchanged, resume=0, CHANGE (rewind and stop).
  SEQ: if song==NUM_SONGS-1 -> song=0, resume=0; else song+1, resume=1; CHANGE.
  LOOP: song+1 with wrap, resume=1, CHANGE.
  SHUFFLE: cand=lfsr[SONG_W-1:0]; if cand>=NUM_SONGS cand-=NUM_SONGS; if cand==song cand=song+1 with wrap; song=cand, resume=1, CHANGE.
- CHANGE: lasts exactly one cycle; all inputs ignored; next state PLAYING if resume else PAUSED.
- next/prev in SHUFFLE mode are sequential (no randomisation).
- song never leaves 0..NUM_SONGS-1; arithmetic done in SONG_W+1 bits then compared, no reliance on natural overflow when NUM_SONGS<2**SONG_W.
- Reset mid-CHANGE or mid-play: immediate return to reset values regardless of state.

Decomposition:
- Shared package mcu_pkg: state encoding constants (PAUSED=2'd0, PLAYING=2'd1, CHANGE=2'd2), mode constants (MODE_STOP..MODE_SHUFFLE), LFSR tap constant.
- One sub-module: lfsr8 (clk, reset, seed parameter, 8-bit state out), reused by later shuffle features.
- Next-song index selection kept as combinational logic inside mcu_seq.

Test Plan:
- Reset: hold reset=0 3 cycles -> play=0, reset_player=1, song=0; release -> reset_player=0 next edge, state PAUSED.
- Play toggle: play_button pulse -> play=1 one cycle later; second pulse -> play=0, song unchanged, reset_player stays 0.
- Next/prev wrap (NUM_SONGS=3, SONG_W=2): while playing at song 2, next -> song=0, reset_player=1 for exactly 1 cycle, then play=1; prev at 0 -> song=2; while paused, next -> CHANGE then play=0.
- Modes: playing song 3 (NUM_SONGS=4), song_done in SEQ -> song=0, ends PAUSED; LOOP -> song=0, PLAYING; STOP at song 1 -> song=1, reset_player pulse, PAUSED.
- Shuffle: mode=3, 50 song_done pulses -> song always <NUM_SONGS and never equals previous song; sequence repeatable for LFSR_SEED=8'hA5.
- Coincidence/reset: song_done+next+play same cycle in LOOP at song 0 -> song=1 (single advance), PLAYING; next during CHANGE ignored; reset=0 during CHANGE -> song=0, play=0 immediately.
